// File: rtl/riscv_mem_pkg.sv
// Shared types and limits for the unified memory port arbiter.
// Latency: n/a (types, constants and a constant helper only).
// Backpressure: n/a.
package riscv_mem_pkg;

    // Access sequencer states; the arbiter is only willing to pick a new owner in IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RETURN = 2'd3
    } state_e;

    // Which requester currently owns the memory port.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    // Legal range of the memory read latency; the counter is sized from it.
    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 15;

    function automatic bit read_latency_ok(input int lat);
        return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational owner picker for the shared memory port.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller only consults it while the port is idle.
//
// Config macro: MEM_ARB_ROUND_ROBIN_EN
//   defined     -> on a tie the port that did not win last time is picked
//   not defined -> fixed priority, CPU always wins a tie (DMA can starve
//                  under continuous CPU traffic); no last_owner input exists
// Ports:
//   last_owner   in  previous grant winner (round-robin build only)
//   cpu_req      in  CPU request
//   dma_req      in  loader/DMA request
//   grant_valid  out some requester can be granted
//   owner        out which requester to grant (OWN_CPU when nobody asks)
module mem_arb_picker
    import riscv_mem_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  owner_e last_owner,
`endif
    input  logic   cpu_req,
    input  logic   dma_req,
    output logic   grant_valid,
    output owner_e owner
);

    always_comb begin
        grant_valid = cpu_req | dma_req;
        owner       = OWN_CPU;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (cpu_req && dma_req) begin
            // Alternate on contention so neither side can be starved.
            owner = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
        end else if (dma_req) begin
            owner = OWN_DMA;
        end
`else
        if (!cpu_req && dma_req) begin
            owner = OWN_DMA;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU and the program loader/DMA, one access in flight.
// Latency: gnt 1 cycle after req seen idle; write done that cycle; rvalid at 2+READ_LATENCY.
// Backpressure: requests are held off (no gnt) while an access is in flight; requester holds fields until gnt.
//
// Config macro: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_picker); when undefined the
// last_owner register is not built and the CPU has fixed priority.
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   cpu_req/we/addr/wdata         CPU request side
//   cpu_gnt/rvalid/rdata          CPU grant pulse, read-return pulse, registered read data
//   dma_*                         same set for the loader port
//   mem_addr/mem_we/mem_wdata     registered memory command (mem_we high only in a write ACCESS)
//   mem_rdata                     memory read data, valid READ_LATENCY cycles after the address cycle
//   busy                          an access is in progress (state != IDLE)
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam int CNT_W = $clog2(READ_LATENCY + 1);

    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_read_latency
        $error("mem_port_arbiter: READ_LATENCY %0d outside %0d..%0d",
               READ_LATENCY, READ_LATENCY_MIN, READ_LATENCY_MAX);
    end

    state_e            state_q,      state_d;
    owner_e            owner_q,      owner_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic              mem_we_q,     mem_we_d;
    logic              cpu_gnt_q,    cpu_gnt_d;
    logic              dma_gnt_q,    dma_gnt_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              dma_rvalid_q, dma_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q,  dma_rdata_d;
    logic              busy_q,       busy_d;

    logic              pick_vld;
    owner_e            pick_owner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e            last_owner_q, last_owner_d;
`endif

    mem_arb_picker u_picker (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_owner  (last_owner_q),
`endif
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .grant_valid (pick_vld),
        .owner       (pick_owner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        cpu_gnt_d    = 1'b0;
        dma_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        dma_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;

        unique case (state_q)
            IDLE: begin
                // The command and the grant pulse are loaded together so that
                // both appear in the same (ACCESS) cycle.
                if (pick_vld) begin
                    owner_d = pick_owner;
                    state_d = ACCESS;
                    if (pick_owner == OWN_CPU) begin
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                        mem_we_d    = cpu_we;
                        cpu_gnt_d   = 1'b1;
                    end else begin
                        mem_addr_d  = dma_addr;
                        mem_wdata_d = dma_wdata;
                        mem_we_d    = dma_we;
                        dma_gnt_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // mem_we_q doubles as "this access is a write".
                if (mem_we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                end
            end
            WAIT: begin
                // cnt reaches zero in the cycle mem_rdata becomes valid.
                if (cnt_q == '0) begin
                    state_d = RETURN;
                    if (owner_q == OWN_CPU) begin
                        cpu_rdata_d  = mem_rdata;
                        cpu_rvalid_d = 1'b1;
                    end else begin
                        dma_rdata_d  = mem_rdata;
                        dma_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RETURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == IDLE && pick_vld) begin
            last_owner_d = pick_owner;
        end
    end

    // Reset to DMA so the first contested grant goes to the CPU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= OWN_DMA;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dma_gnt_q    <= dma_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign dma_gnt    = dma_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed literal cases plus randomized traffic
// against a transaction-timing model (gnt at t0+1, rvalid at t0+2+RL).
// Memory is a pure function of address, valid only RL cycles after a read address cycle.
module tb_mem_port_arbiter;

    localparam int RL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, busy;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(RL)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0051_3093;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Memory: read data appears exactly RL cycles after a read address cycle, junk otherwise.
    logic        rv [16];
    logic [31:0] ra [16];
    logic [31:0] junk;
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                rv[i] <= 1'b0;
                ra[i] <= '0;
            end
        end else begin
            rv[0] <= (cpu_gnt || dma_gnt) && !mem_we;
            ra[0] <= mem_addr;
            for (int i = 1; i < 16; i++) begin
                rv[i] <= rv[i-1];
                ra[i] <= ra[i-1];
            end
        end
        junk <= $urandom;
    end
    assign mem_rdata = rv[RL-1] ? mem_f(ra[RL-1]) : junk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    int          cyc = 0;
    bit          m_active = 0;
    int          m_owner = 0;   // 0 = CPU, 1 = DMA
    int          m_last = 1;
    bit          m_we = 0;
    int          m_t0 = 0, m_free = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic [31:0] exp_rd [2];

    initial begin : compare
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (!rst) begin
                m_active  = 0;
                m_last    = 1;
                exp_addr  = '0;
                exp_wdata = '0;
                exp_rd[0] = '0;
                exp_rd[1] = '0;
            end else if (m_active && !m_we && cyc == m_t0 + 2 + RL) begin
                exp_rd[m_owner] = mem_f(m_addr);
            end
            begin
                bit g, rvl, bsy;
                g   = m_active && (cyc == m_t0 + 1);
                rvl = m_active && !m_we && (cyc == m_t0 + 2 + RL);
                bsy = m_active && (cyc >= m_t0 + 1) && (cyc < m_free);
                chk("m_cpu_gnt",    cpu_gnt,    g   && m_owner == 0);
                chk("m_dma_gnt",    dma_gnt,    g   && m_owner == 1);
                chk("m_cpu_rvalid", cpu_rvalid, rvl && m_owner == 0);
                chk("m_dma_rvalid", dma_rvalid, rvl && m_owner == 1);
                chk("m_cpu_rdata",  cpu_rdata,  exp_rd[0]);
                chk("m_dma_rdata",  dma_rdata,  exp_rd[1]);
                chk("m_mem_we",     mem_we,     g && m_we);
                chk("m_mem_addr",   mem_addr,   exp_addr);
                chk("m_mem_wdata",  mem_wdata,  exp_wdata);
                chk("m_busy",       busy,       bsy);
                chk("one_gnt",      cpu_gnt && dma_gnt, 1'b0);
                chk("we_one_gnt",   mem_we && !(cpu_gnt ^ dma_gnt), 1'b0);
            end
            if (rst && (!m_active || cyc >= m_free) && (cpu_req || dma_req)) begin
                int own;
                if (cpu_req && dma_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    own = (m_last == 1) ? 0 : 1;
`else
                    own = 0;
`endif
                end else begin
                    own = cpu_req ? 0 : 1;
                end
                m_owner   = own;
                m_last    = own;
                m_we      = (own == 0) ? cpu_we : dma_we;
                m_addr    = (own == 0) ? cpu_addr : dma_addr;
                exp_addr  = m_addr;
                exp_wdata = (own == 0) ? cpu_wdata : dma_wdata;
                m_t0      = cyc;
                m_free    = m_we ? cyc + 2 : cyc + 3 + RL;
                m_active  = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int          ngr;
        int          nrv;
        logic [3:0]  seq;
        bit          gc, gd;

        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",     busy,      1'b0);
        chk("rst_mem_addr", mem_addr,  32'h0);
        chk("rst_cpu_gnt",  cpu_gnt,   1'b0);
        chk("rst_rdata",    cpu_rdata, 32'h0);
        @(posedge clk); #3 rst = 1'b1;

        // CPU read of 0x10 at cycle 0; DMA write raised at cycle 2, must wait for rvalid.
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0010; cpu_wdata = 32'h1111_2222;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k == 1) cpu_req = 0;
            if (k == 2) begin
                dma_req = 1; dma_we = 1; dma_addr = 32'h0000_0100; dma_wdata = 32'hDEAD_BEEF;
            end
            if (k == 8) dma_req = 0;
            @(negedge clk);
            if (k == 1) begin
                chk("t1_cpu_gnt",  cpu_gnt,  1'b1);
                chk("t1_mem_addr", mem_addr, 32'h0000_0010);
                chk("t1_mem_we",   mem_we,   1'b0);
            end
            if (k == 5) chk("t4_rvalid_early", cpu_rvalid, 1'b0);
            if (k == 6) begin
                chk("t4_cpu_rvalid", cpu_rvalid, 1'b1);
                chk("t1_cpu_rdata",  cpu_rdata,  32'h0051_3093);
                chk("t1_dma_rvalid", dma_rvalid, 1'b0);
                chk("t1_dma_rdata",  dma_rdata,  32'h0);
            end
            if (k == 7) chk("t4_dma_gnt_early", dma_gnt, 1'b0);
            if (k == 8) begin
                chk("t4_dma_gnt",   dma_gnt,   1'b1);
                chk("t2_mem_we",    mem_we,    1'b1);
                chk("t2_mem_addr",  mem_addr,  32'h0000_0100);
                chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            end
            if (k == 9) begin
                chk("t2_mem_we_drop", mem_we, 1'b0);
                chk("t2_busy_drop",   busy,   1'b0);
            end
        end

        // Both requesters read continuously; record the first four winners.
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0040;
        dma_req = 1; dma_we = 0; dma_addr = 32'h0000_0080;
        ngr = 0; seq = '0;
        for (int k = 0; k <= 22; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            if ((cpu_gnt || dma_gnt) && ngr < 4) begin
                seq[ngr] = dma_gnt;
                ngr++;
            end
        end
        chk("t3_grant_count", ngr, 4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("t3_grant_order", seq, 4'b1010);
`else
        chk("t3_grant_order", seq, 4'b0000);
`endif
        @(posedge clk); #1;
        cpu_req = 0; dma_req = 0;
        repeat (10) @(posedge clk);

        // Reset in the middle of a read's WAIT phase.
        #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0020;
        @(posedge clk); #1; cpu_req = 0;
        @(posedge clk);
        @(posedge clk); #3 rst = 1'b0;
        #1;
        chk("t5_busy",       busy,       1'b0);
        chk("t5_cpu_gnt",    cpu_gnt,    1'b0);
        chk("t5_mem_addr",   mem_addr,   32'h0);
        chk("t5_cpu_rdata",  cpu_rdata,  32'h0);
        chk("t5_dma_rdata",  dma_rdata,  32'h0);
        @(posedge clk); #3 rst = 1'b1;
        nrv = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (cpu_rvalid || dma_rvalid) nrv++;
        end
        chk("t5_no_rvalid", nrv, 0);
        @(posedge clk); #1;
        dma_req = 1; dma_we = 0; dma_addr = 32'h0000_0010;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k == 1) dma_req = 0;
            @(negedge clk);
            if (k == 1) chk("t5_dma_gnt", dma_gnt, 1'b1);
            if (k == 6) begin
                chk("t5_dma_rvalid", dma_rvalid, 1'b1);
                chk("t5_dma_rdata",  dma_rdata,  32'h0051_3093);
            end
        end

        // Randomized traffic: each side holds its request until granted.
        gc = 0; gd = 0;
        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            gc = cpu_gnt;
            gd = dma_gnt;
            @(posedge clk); #1;
            if (gc) cpu_req = 0;
            if (gd) dma_req = 0;
            if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req   = 1;
                cpu_we    = $urandom_range(0, 1) == 1;
                cpu_addr  = $urandom & 32'h0000_FFFC;
                cpu_wdata = $urandom;
            end
            if (!dma_req && $urandom_range(0, 2) == 0) begin
                dma_req   = 1;
                dma_we    = $urandom_range(0, 1) == 1;
                dma_addr  = $urandom & 32'h0000_FFFC;
                dma_wdata = $urandom;
            end
        end
        @(negedge clk);
        @(posedge clk); #1;
        cpu_req = 0; dma_req = 0;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
